// File: rtl/flog_top_if.sv
// bfloat16 field widths and the operand/result bus of the FLOG log2 unit.
// The source drives operands through the master modport; the unit takes the slave side.
package flog_pkg;
  localparam int EXP_WIDTH   = 8;
  localparam int FRACT_WIDTH = 7;
endpackage

interface flog_top_if;
  import flog_pkg::*;

  logic                   sign;
  logic [EXP_WIDTH-1:0]   exponent;
  logic [FRACT_WIDTH-1:0] fractional;
  logic                   valid_i;
  logic                   s_res_o;
  logic [EXP_WIDTH-1:0]   e_res_o;
  logic [FRACT_WIDTH-1:0] f_res_o;
  logic                   valid_o;

  modport master (
    output sign, exponent, fractional, valid_i,
    input  s_res_o, e_res_o, f_res_o, valid_o
  );

  modport slave (
    input  sign, exponent, fractional, valid_i,
    output s_res_o, e_res_o, f_res_o, valid_o
  );
endinterface

// File: rtl/flog_top.sv
// Pipelined bfloat16 log2: capture/decode, LUT + fixed-point add, normalize, round.
// Each operand appears on the outputs three edges after it is sampled.
module flog_top
  import flog_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  flog_top_if.slave  bus
);

  // round(log2(1+k/128)*2^16), computed at elaboration by repeated squaring
  function automatic logic [15:0] lut_entry(input int k);
    logic [63:0]  y;
    logic [127:0] sq;
    logic [23:0]  bits;
    logic [24:0]  rnd;
    y    = 64'h4000_0000_0000_0000 + (64'(k) << 55);
    bits = 24'h000000;
    for (int i = 23; i >= 0; i--) begin
      sq = 128'(y) * 128'(y);
      if (sq[125]) begin
        bits[i] = 1'b1;
        y       = sq[126:63];
      end else begin
        bits[i] = 1'b0;
        y       = sq[125:62];
      end
    end
    rnd = {1'b0, bits} + 25'd128;
    return rnd[23:8];
  endfunction

  function automatic logic [4:0] msb_pos(input logic [22:0] v);
    logic [4:0] p;
    p = 5'd0;
    for (int i = 0; i < 23; i++) begin
      if (v[i]) begin
        p = 5'(i);
      end else begin
        p = p;
      end
    end
    return p;
  endfunction

  logic [15:0] lut_s [128];

  for (genvar g = 0; g < 128; g++) begin : g_lut
    localparam logic [15:0] ENTRY = lut_entry(g);
    assign lut_s[g] = ENTRY;
  end

  // ---------------- stage 1: capture and special-case decode ----------------
  logic                   spec_s, sp_sign_s;
  logic [EXP_WIDTH-1:0]   sp_exp_s;
  logic [FRACT_WIDTH-1:0] sp_fract_s;

  // Zero/subnormal -> -inf, +inf -> +inf, NaN or negative -> canonical NaN
  always_comb begin
    spec_s     = 1'b1;
    sp_sign_s  = 1'b0;
    sp_exp_s   = {EXP_WIDTH{1'b1}};
    sp_fract_s = {1'b1, {(FRACT_WIDTH-1){1'b0}}};
    if (bus.exponent == {EXP_WIDTH{1'b0}}) begin
      sp_sign_s  = 1'b1;
      sp_fract_s = {FRACT_WIDTH{1'b0}};
    end else if (bus.exponent == {EXP_WIDTH{1'b1}}) begin
      if (!bus.sign && bus.fractional == {FRACT_WIDTH{1'b0}}) begin
        sp_fract_s = {FRACT_WIDTH{1'b0}};
      end else begin
        sp_fract_s = {1'b1, {(FRACT_WIDTH-1){1'b0}}};
      end
    end else if (bus.sign) begin
      sp_sign_s = 1'b0;
    end else begin
      spec_s = 1'b0;
    end
  end

  logic                   v1_r, spec1_r, sps1_r;
  logic [EXP_WIDTH-1:0]   exp1_r, spe1_r;
  logic [FRACT_WIDTH-1:0] fract1_r, spf1_r;

  // Stage 1 valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) v1_r <= 1'b0;
    else     v1_r <= bus.valid_i;
  end

  // Stage 1 data, loaded only with a sampled operand
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spec1_r <= 1'b0; sps1_r <= 1'b0; spe1_r <= 8'h00; spf1_r <= 7'h00;
      exp1_r  <= 8'h00; fract1_r <= 7'h00;
    end else if (bus.valid_i) begin
      spec1_r <= spec_s; sps1_r <= sp_sign_s; spe1_r <= sp_exp_s; spf1_r <= sp_fract_s;
      exp1_r  <= bus.exponent; fract1_r <= bus.fractional;
    end
  end

  // ---------------- stage 2: LUT lookup and S = E*2^16 + L[k] ----------------
  logic [7:0]  exp_ofs_s;
  logic [23:0] sum_s;
  logic [22:0] mag_s;

  // Only the low 8 bits of E matter: S fits in 24-bit two's complement
  always_comb begin
    exp_ofs_s = exp1_r - 8'd127;
    sum_s     = {exp_ofs_s, 16'h0000} + {8'h00, lut_s[fract1_r]};
    if (sum_s[23]) mag_s = 23'(24'h000000 - sum_s);
    else           mag_s = 23'(sum_s);
  end

  logic                   v2_r, neg2_r, spec2_r, sps2_r;
  logic [22:0]            mag2_r;
  logic [EXP_WIDTH-1:0]   spe2_r;
  logic [FRACT_WIDTH-1:0] spf2_r;

  // Stage 2 valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) v2_r <= 1'b0;
    else     v2_r <= v1_r;
  end

  // Stage 2 data: sign and magnitude of S
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg2_r <= 1'b0; mag2_r <= 23'd0;
      spec2_r <= 1'b0; sps2_r <= 1'b0; spe2_r <= 8'h00; spf2_r <= 7'h00;
    end else if (v1_r) begin
      neg2_r <= sum_s[23]; mag2_r <= mag_s;
      spec2_r <= spec1_r; sps2_r <= sps1_r; spe2_r <= spe1_r; spf2_r <= spf1_r;
    end
  end

  // ---------------- stage 3: normalize ----------------
  logic [4:0]  p_s;
  logic [21:0] norm_s;
  logic        zero_s;

  // Left-justify M so its leading one sits just above bit 21
  always_comb begin
    p_s    = msb_pos(mag2_r);
    zero_s = (mag2_r == 23'd0);
    norm_s = 22'(mag2_r << (5'd22 - p_s));
  end

  logic                   v3_r, neg3_r, zero3_r, spec3_r, sps3_r;
  logic [4:0]             p3_r;
  logic [21:0]            norm3_r;
  logic [EXP_WIDTH-1:0]   spe3_r;
  logic [FRACT_WIDTH-1:0] spf3_r;

  // Stage 3 valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) v3_r <= 1'b0;
    else     v3_r <= v2_r;
  end

  // Stage 3 data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg3_r <= 1'b0; zero3_r <= 1'b0; p3_r <= 5'd0; norm3_r <= 22'd0;
      spec3_r <= 1'b0; sps3_r <= 1'b0; spe3_r <= 8'h00; spf3_r <= 7'h00;
    end else if (v2_r) begin
      neg3_r <= neg2_r; zero3_r <= zero_s; p3_r <= p_s; norm3_r <= norm_s;
      spec3_r <= spec2_r; sps3_r <= sps2_r; spe3_r <= spe2_r; spf3_r <= spf2_r;
    end
  end

  // ---------------- round and select into the output registers ----------------
  logic                   inc_s, res_sign_s;
  logic [7:0]             rnd_s;
  logic [EXP_WIDTH-1:0]   res_exp_s;
  logic [FRACT_WIDTH-1:0] res_fract_s;

  // Round to nearest even; a fraction carry bumps the exponent and wraps the fraction to 0
  always_comb begin
    inc_s = norm3_r[14] & ((|norm3_r[13:0]) | norm3_r[15]);
    rnd_s = {1'b0, norm3_r[21:15]} + {7'd0, inc_s};
    if (spec3_r) begin
      res_sign_s  = sps3_r;
      res_exp_s   = spe3_r;
      res_fract_s = spf3_r;
    end else if (zero3_r) begin
      res_sign_s  = 1'b0;
      res_exp_s   = 8'h00;
      res_fract_s = 7'h00;
    end else begin
      res_sign_s  = neg3_r;
      res_exp_s   = 8'd111 + {3'b000, p3_r} + {7'd0, rnd_s[7]};
      res_fract_s = rnd_s[6:0];
    end
  end

  logic                   valid_r, s_res_r;
  logic [EXP_WIDTH-1:0]   e_res_r;
  logic [FRACT_WIDTH-1:0] f_res_r;

  // Output valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_r <= 1'b0;
    else     valid_r <= v3_r;
  end

  // Output data holds the last result between valid stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_res_r <= 1'b0; e_res_r <= 8'h00; f_res_r <= 7'h00;
    end else if (v3_r) begin
      s_res_r <= res_sign_s; e_res_r <= res_exp_s; f_res_r <= res_fract_s;
    end
  end

  assign bus.valid_o = valid_r;
  assign bus.s_res_o = s_res_r;
  assign bus.e_res_o = e_res_r;
  assign bus.f_res_o = f_res_r;

endmodule

// File: tb/tb_flog_top.sv
// Directed bench for flog_top: latency, special cases, streaming and reset behaviour.
module tb_flog_top;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   err_cnt = 0;
  int   chk_cnt = 0;

  flog_top_if bus ();

  flog_top dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] res();
    return {bus.s_res_o, bus.e_res_o, bus.f_res_o};
  endfunction

  // One isolated operand: check latency, result and single-cycle valid_o
  task automatic run_one(input string tag, input logic [15:0] op, input logic [15:0] exp_res);
    @(negedge clk);
    {bus.sign, bus.exponent, bus.fractional} = op;
    bus.valid_i = 1'b1;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check_eq({tag, "_early"}, 32'(bus.valid_o), 32'd0);
    @(posedge clk); #1;
    check_eq({tag, "_valid"}, 32'(bus.valid_o), 32'd1);
    check_eq({tag, "_res"}, 32'(res()), 32'(exp_res));
    @(posedge clk); #1;
    check_eq({tag, "_pulse"}, 32'(bus.valid_o), 32'd0);
  endtask

  initial begin
    bus.sign = 1'b0; bus.exponent = 8'h80; bus.fractional = 7'h00; bus.valid_i = 1'b1;
    // reset held two cycles with valid operands driven
    @(posedge clk); #1;
    check_eq("rst_c1", {15'd0, bus.valid_o, res()}, 32'd0);
    @(posedge clk); #1;
    check_eq("rst_c2", {15'd0, bus.valid_o, res()}, 32'd0);
    @(negedge clk);
    bus.valid_i = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_eq("post_rst_idle", {15'd0, bus.valid_o, res()}, 32'd0);
    end

    run_one("large",    {1'b0, 8'hE5, 7'h2D}, {1'b0, 8'h85, 7'h4D});
    run_one("near_two", {1'b0, 8'd143, 7'h7A}, {1'b0, 8'h83, 7'h08});
    run_one("one",      {1'b0, 8'h7F, 7'h00}, 16'h0000);
    run_one("half",     {1'b0, 8'h7E, 7'h00}, {1'b1, 8'h7F, 7'h00});
    run_one("max_exp",  {1'b0, 8'hFE, 7'h00}, {1'b0, 8'h85, 7'h7E});
    run_one("min_norm", {1'b0, 8'h01, 7'h00}, {1'b1, 8'h85, 7'h7C});
    run_one("pos_zero", {1'b0, 8'h00, 7'h00}, {1'b1, 8'hFF, 7'h00});
    run_one("neg_sub",  {1'b1, 8'h00, 7'h05}, {1'b1, 8'hFF, 7'h00});
    run_one("pos_inf",  {1'b0, 8'hFF, 7'h00}, {1'b0, 8'hFF, 7'h00});
    run_one("nan_in",   {1'b0, 8'hFF, 7'h01}, {1'b0, 8'hFF, 7'h40});
    run_one("neg_fin",  {1'b1, 8'h80, 7'h00}, {1'b0, 8'hFF, 7'h40});

    // streaming 1.0, 2.0, 4.0 back to back
    @(negedge clk);
    bus.valid_i = 1'b1; {bus.sign, bus.exponent, bus.fractional} = {1'b0, 8'h7F, 7'h00};
    @(negedge clk);
    {bus.sign, bus.exponent, bus.fractional} = {1'b0, 8'h80, 7'h00};
    @(negedge clk);
    {bus.sign, bus.exponent, bus.fractional} = {1'b0, 8'h81, 7'h00};
    @(negedge clk);
    bus.valid_i = 1'b0;
    @(posedge clk); #1;
    check_eq("strm_0", {15'd0, bus.valid_o, res()}, {15'd0, 1'b1, 16'h0000});
    @(posedge clk); #1;
    check_eq("strm_1", {15'd0, bus.valid_o, res()}, {15'd0, 1'b1, 16'h3F80});
    @(posedge clk); #1;
    check_eq("strm_2", {15'd0, bus.valid_o, res()}, {15'd0, 1'b1, 16'h4000});
    @(posedge clk); #1;
    check_eq("strm_end", {15'd0, bus.valid_o, res()}, {15'd0, 1'b0, 16'h4000});

    // static operand 2.0, then reset while the pipeline is full
    @(negedge clk);
    bus.valid_i = 1'b1; {bus.sign, bus.exponent, bus.fractional} = {1'b0, 8'h80, 7'h00};
    for (int i = 0; i < 3; i++) @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check_eq("static", {15'd0, bus.valid_o, res()}, {15'd0, 1'b1, 16'h3F80});
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("mid_rst", {15'd0, bus.valid_o, res()}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_eq("flushed", 32'(bus.valid_o), 32'd0);
    end
    run_one("after_rst", {1'b0, 8'h81, 7'h00}, 16'h4000);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
